// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the unaligned memory access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_seq_pkg;

    localparam int ADDR_W     = 32;
    localparam int MAX_CHUNKS = 3;

    localparam logic [3:0] W_BYTE = 4'h1;
    localparam logic [3:0] W_HALF = 4'h2;
    localparam logic [3:0] W_WORD = 4'h4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        LWAIT,
        RESP
    } state_t;

    // Keeps only the low w bytes of a right-aligned chunk.
    function automatic logic [31:0] lane_mask(input logic [2:0] w);
        case (w)
            3'd1:    lane_mask = 32'h0000_00FF;
            3'd2:    lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_seq_chunk.sv
// Picks the widest naturally aligned chunk for the current address and remaining bytes.
// Latency: combinational.
// Backpressure: none.
module mem_seq_chunk
    import mem_seq_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] rem,
    output logic [2:0] w,
    output logic [3:0] mem_width
);

    always_comb begin
        mem_width = W_BYTE;
        if (addr_lo == 2'b00 && rem >= 3'd4) begin
            mem_width = W_WORD;
        end else if (!addr_lo[0] && rem >= 3'd2) begin
            mem_width = W_HALF;
        end
        w = mem_width[2:0];
    end

endmodule

// File: rtl/mem_access_seq.sv
// Splits 1..4 byte loads/stores into aligned chunks; MEM_SEQ_ERR_EN adds len/4KB-crossing checks.
// Latency: store chunks+1, load 2*chunks+1 cycles from accept to resp_valid.
// Backpressure: req_ready only in IDLE; mem stage never stalls, load data returns the cycle after issue.
module mem_access_seq
    import mem_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_len,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_width,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state_q;
    state_t            state_nxt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       acc_q;
    logic [2:0]        rem_q;
    logic [2:0]        w_q;
    logic [2:0]        chunk_w;
    logic [3:0]        chunk_width;
    logic [5:0]        chunk_bits;
    logic [2:0]        len_eff;
    logic              req_err;
    logic              accept;

    mem_seq_chunk u_chunk (
        .addr_lo   (addr_q[1:0]),
        .rem       (rem_q),
        .w         (chunk_w),
        .mem_width (chunk_width)
    );

    assign chunk_bits = {chunk_w, 3'b000};
    assign req_ready  = (state_q == IDLE) && !rst;
    assign accept     = req_valid && req_ready;

`ifdef MEM_SEQ_ERR_EN
    logic        err_q;
    logic [19:0] last_page;

    assign last_page  = 20'((req_addr + {29'd0, req_len} - 32'd1) >> 12);
    assign req_err    = (req_len == 3'd0) || (req_len > 3'd4) || (last_page != req_addr[31:12]);
    assign len_eff    = req_len;
    assign resp_err   = resp_valid && err_q;
`else
    assign req_err    = 1'b0;
    assign len_eff    = (req_len > 3'd4) ? 3'd4 : req_len;
    assign resp_err   = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_nxt = (req_err || len_eff == 3'd0) ? RESP : ACCESS;
            ACCESS: begin
                if (!we_q) begin
                    state_nxt = LWAIT;
                end else if (rem_q == chunk_w) begin
                    state_nxt = RESP;
                end
            end
            LWAIT:   state_nxt = (rem_q == 3'd0) ? RESP : ACCESS;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_ce     = (state_q == ACCESS);
    assign mem_we     = mem_ce && we_q;
    assign mem_addr   = mem_ce ? addr_q : '0;
    assign mem_width  = mem_ce ? chunk_width : '0;
    // Store data is held left-aligned so the next chunk is always the top bytes.
    assign mem_wdata  = mem_we ? (wdata_q >> (6'd32 - chunk_bits)) : '0;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? acc_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            w_q     <= '0;
`ifdef MEM_SEQ_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        rem_q   <= len_eff;
                        wdata_q <= req_wdata << {3'd4 - len_eff, 3'b000};
                        acc_q   <= '0;
`ifdef MEM_SEQ_ERR_EN
                        err_q   <= req_err;
`endif
                    end
                end
                ACCESS: begin
                    addr_q  <= addr_q + {29'd0, chunk_w};
                    rem_q   <= rem_q - chunk_w;
                    wdata_q <= wdata_q << chunk_bits;
                    w_q     <= chunk_w;
                end
                LWAIT: begin
                    acc_q <= (acc_q << {w_q, 3'b000}) | (mem_rdata & lane_mask(w_q));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: directed cases plus random requests against a byte-level memory model.
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_len;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_width;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mm [logic [31:0]];
    logic [31:0] q_addr [$];
    logic [3:0]  q_wid  [$];
    logic [31:0] q_data [$];

    always #5 clk = ~clk;

    mem_access_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_width  (mem_width),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mm.exists(a)) return mm[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory-side emulator: answers a load chunk with junk above the chunk bytes.
    task automatic answer_load();
        logic [31:0] d;
        logic [31:0] m;
        int          w;
        d = '0;
        w = int'(mem_width);
        for (int j = 0; j < w; j++) d = (d << 8) | 32'(mem_byte(mem_addr + 32'(j)));
        m = (w >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * w)) - 32'd1);
        mem_rdata = ($urandom & ~m) | d;
    endtask

    task automatic run_req(input logic we, input logic [31:0] addr, input logic [2:0] len,
                           input logic [31:0] wdata, input bit keep);
        int          n_eff;
        int          r;
        int          k;
        int          w;
        int          lat;
        bit          err;
        bit          done;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [31:0] last;
        logic [7:0]  sb [4];

        err   = 1'b0;
        n_eff = (len > 3'd4) ? 4 : int'(len);
`ifdef MEM_SEQ_ERR_EN
        last = addr + 32'(len) - 32'd1;
        if (len == 3'd0 || len > 3'd4 || last[31:12] != addr[31:12]) err = 1'b1;
`endif
        if (err) n_eff = 0;

        for (int i = 0; i < 4; i++) sb[i] = 8'h00;
        for (int i = 0; i < n_eff; i++) sb[i] = 8'(wdata >> (8 * (n_eff - 1 - i)));

        exp_rd = '0;
        if (!we) for (int i = 0; i < n_eff; i++) exp_rd = (exp_rd << 8) | 32'(mem_byte(addr + 32'(i)));

        q_addr.delete(); q_wid.delete(); q_data.delete();
        a = addr; r = n_eff; k = 0;
        while (r > 0) begin
            if (a % 4 == 0 && r >= 4)      w = 4;
            else if (a % 2 == 0 && r >= 2) w = 2;
            else                           w = 1;
            d = '0;
            for (int j = 0; j < w; j++) d = (d << 8) | 32'(sb[k + j]);
            q_addr.push_back(a);
            q_wid.push_back(4'(w));
            q_data.push_back(we ? d : 32'd0);
            a = a + 32'(w); r -= w; k += w;
        end
        lat = we ? q_addr.size() + 1 : 2 * q_addr.size() + 1;
        if (we) for (int i = 0; i < n_eff; i++) mm[addr + 32'(i)] = sb[i];

        @(negedge clk);
        req_we = we; req_addr = addr; req_len = len; req_wdata = wdata; req_valid = 1'b1;
        chk("ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;

        done = 1'b0;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(negedge clk);
            if (mem_ce) begin
                if (q_addr.size() == 0) begin
                    chk("extra_chunk", 32'(mem_ce), 32'd0);
                end else begin
                    chk("chunk_addr",  mem_addr, q_addr[0]);
                    chk("chunk_width", 32'(mem_width), 32'(q_wid[0]));
                    chk("chunk_we",    32'(mem_we), 32'(we));
                    chk("chunk_wdata", mem_wdata, q_data[0]);
                    void'(q_addr.pop_front()); void'(q_wid.pop_front()); void'(q_data.pop_front());
                end
                if (!mem_we) answer_load();
            end else begin
                chk("bus_quiet", {27'd0, mem_we, mem_width} | mem_addr | mem_wdata, 32'd0);
            end
            if (resp_valid) begin
                chk("latency",       32'(c), 32'(lat));
                chk("resp_rdata",    resp_rdata, we ? 32'd0 : exp_rd);
                chk("resp_err",      32'(resp_err), 32'(err));
                chk("ready_in_resp", 32'(req_ready), 32'd0);
                chk("chunks_left",   32'(q_addr.size()), 32'd0);
                done = 1'b1;
            end
        end
        if (!done) chk("resp_timeout", 32'(resp_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        we;
        logic [31:0] addr;
        logic [2:0]  len;
        int          sel;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_len = '0; req_wdata = '0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",      32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp",       resp_rdata | 32'(resp_err), 32'd0);
        chk("rst_mem_ce",     32'(mem_ce), 32'd0);
        chk("rst_bus",        {27'd0, mem_we, mem_width} | mem_addr | mem_wdata, 32'd0);

        run_req(1'b1, 32'h0000_0100, 3'd4, 32'hA1B2_C3D4, 1'b0);
        mm[32'h101] = 8'h11; mm[32'h102] = 8'h22; mm[32'h103] = 8'h33; mm[32'h104] = 8'h44;
        run_req(1'b0, 32'h0000_0101, 3'd4, 32'h0, 1'b0);
        run_req(1'b1, 32'h0000_0203, 3'd2, 32'h0000_BEEF, 1'b0);
        run_req(1'b0, 32'h0000_0203, 3'd2, 32'h0, 1'b0);
        run_req(1'b0, 32'h0000_0FFE, 3'd4, 32'h0, 1'b0);
        run_req(1'b1, 32'h0000_0300, 3'd0, 32'h1234_5678, 1'b0);
        run_req(1'b0, 32'h0000_0100, 3'd6, 32'h0, 1'b0);
        run_req(1'b1, 32'h0000_0400, 3'd1, 32'h0000_005A, 1'b1);
        run_req(1'b0, 32'h0000_0400, 3'd1, 32'h0, 1'b0);

        // Abort a three-chunk load while it waits for its first data beat.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h0000_0101; req_len = 3'd4; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_first_ce", 32'(mem_ce), 32'd1);
        answer_load();
        @(negedge clk);
        chk("abort_lwait_ce", 32'(mem_ce), 32'd0);
        rst = 1'b1;
        req_we = 1'b1; req_addr = 32'h0000_0500; req_len = 3'd4; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("quiet_after_rst", {30'd0, mem_ce, resp_valid}, 32'd0);
            @(negedge clk);
        end

        for (int n = 0; n < 150; n++) begin
            we  = 1'($urandom % 2);
            sel = int'($urandom % 4);
            case (sel)
                0:       addr = 32'h0000_1000 + ($urandom % 64);
                1:       addr = 32'h0000_2FFC + ($urandom % 8);
                2:       addr = 32'hFFFF_FFFC + ($urandom % 4);
                default: addr = $urandom;
            endcase
            if ($urandom % 8 == 0) len = 3'($urandom % 8);
            else                   len = 3'(1 + $urandom % 4);
            run_req(we, addr, len, $urandom, ($urandom % 4) == 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
